sem_arbiter: RTL and testbench
==============================

// Module: sem_arbiter
// PURPOSE
//  Shares one semaphore token FIFO between N_UNITS 1-bit CPU units.
//  Each unit's controller issues put (sem_data_valid_out) and get (sem_data_read) requests.
//  The arbiter serialises them with a round-robin arbiter and a 4-phase req/ack handshake.
//  It returns data with a valid strobe, and exposes empty/full/count to every unit.
//  Sits between the per-unit controllers and the shared sem_fifo instance.
// PARAMETERS
//  N_UNITS     4   number of CPU units (requesters), >=2
//  DATA_WIDTH  1   token width, matches `DATA_WIDTH
//  DEPTH       8   FIFO entries, power of two
//  IDX_W       2   $clog2(N_UNITS); width of owner index
//  CNT_W       4   $clog2(DEPTH)+1; width of count
// PORTS
//  clk        in   1                   system clock, rising edge
//  rst        in   1                   asynchronous reset, active-high
//  put_req    in   N_UNITS             per-unit put request, held until put_ack
//  put_data   in   N_UNITS*DATA_WIDTH  per-unit token; slice u = [u*DW +: DW]
//  put_ack    out  N_UNITS             one-hot; token accepted
//  get_req    in   N_UNITS             per-unit get request, held until get_valid
//  get_data   out  DATA_WIDTH          token popped for current owner
//  get_valid  out  N_UNITS             one-hot; get_data valid for that unit
//  empty      out  1                   FIFO holds 0 tokens
//  full       out  1                   FIFO holds DEPTH tokens
//  count      out  CNT_W               tokens stored, 0..DEPTH
//  owner      out  IDX_W               unit currently granted (valid when busy=1)
//  busy       out  1                   a transfer is in GRANT or HOLD
// BEHAVIOUR
//  Reset (rst=1, async): state=IDLE, rr_ptr=0, FIFO empty.
//   Outputs after reset: put_ack=0, get_valid=0, get_data=0, owner=0, busy=0, empty=1, full=0, count=0.
//   Reset mid-transfer aborts the transfer; a half-done put/get is not committed.
//  Eligibility (combinational, IDLE only):
//   unit u eligible if (put_req[u] & !full) | (get_req[u] & !empty).
//   A unit asserting both put_req and get_req is an illegal use: put wins, and the get stays pending.
//  FSM:
//   IDLE  -> ARB   when any unit is eligible. Ineligible requests are held pending, never dropped.
//   ARB   winner = first eligible unit at/after rr_ptr, wrapping N_UNITS-1 -> 0.
//         Register owner and op (PUT/GET). rr_ptr <= winner+1 (mod N_UNITS). busy=1.
//   GRANT single cycle. PUT: push put_data[owner], then put_ack[owner]=1 registered next cycle.
//         GET: pop the head, get_data=head, get_valid[owner]=1 registered next cycle.
//   HOLD  ack/valid and get_data are held stable until the owner's req goes low; then -> IDLE and busy=0.
//  Latency: req sampled at cycle 0 in IDLE -> ack/valid high at cycle 3 earliest.
//   Throughput: at most 1 op per 4 cycles.
//  count/empty/full are registered. They update the cycle after the push/pop.
//   They never change outside GRANT.
//  Only one push or pop per transfer. No simultaneous push and pop.
//  Boundaries:
//   full: puts are ineligible and gets still proceed.
//   empty: gets are ineligible and puts still proceed.
//   Pointer wrap at DEPTH is silent (the pointers are IDX bits plus a wrap bit).
//   If owner's req drops in GRANT (protocol violation), the op still commits and HOLD exits next cycle.
//   The round-robin pointer advances only on a grant, never on reset or idle.
// STRUCTURE
//  Sub-module sem_fifo: sync FIFO, DEPTH x DATA_WIDTH.
//   Ports: clk, rst, push, pop, din, dout, empty, full, count.
//   Show-ahead dout. Reset is async and active-high.
//  Shared constants in definy.v:
//   SA_IDLE=2'd0, SA_ARB=2'd1, SA_GRANT=2'd2, SA_HOLD=2'd3
//   SA_OP_PUT=1'b0, SA_OP_GET=1'b1
//  The arbiter FSM and round-robin search live in sem_arbiter itself.
// TESTING
//  1 Reset: pulse rst mid-HOLD -> all outputs at reset values in the same cycle; count=0.
//  2 Single put/get: unit2 puts 1 -> put_ack[2] at cycle 3, count=1.
//    Then unit0 gets -> get_data=1, get_valid=4'b0001, empty=1.
//  3 Round-robin: all 4 units hold put_req -> grant order 0,1,2,3.
//    Units then re-request -> order 0,1,2,3 again (rr_ptr wrap); count=8, full=1.
//  4 Full/empty: FIFO full and unit1 puts while unit3 gets -> unit3 served first.
//    Then unit1 is served; final count=8.
//  5 Empty hold-off: unit1 gets on empty FIFO -> no get_valid for 10 cycles.
//    Unit2 puts 0 -> unit2 acked, then unit1 gets 0.
//  6 Ordering: units push 1,0,1,1 -> four gets return 1,0,1,1 (FIFO order), including across the pointer wrap.

Source files
------------

// File: rtl/sem_arbiter_pkg.sv
// Shared FSM encodings and operation codes for the semaphore arbiter.
// Keeps the state and op values in one place for the arbiter and its bench.
package sem_arbiter_pkg;

    typedef enum logic [1:0] {
        SA_IDLE  = 2'd0,
        SA_ARB   = 2'd1,
        SA_GRANT = 2'd2,
        SA_HOLD  = 2'd3
    } sa_state_t;

    localparam logic SA_OP_PUT = 1'b0;
    localparam logic SA_OP_GET = 1'b1;

endpackage

// File: rtl/sem_fifo.sv
// Synchronous show-ahead token FIFO shared by all units.
// Pointers carry one extra wrap bit, so they roll over at DEPTH without a special case.
module sem_fifo
    import sem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/sem_arbiter.sv
// Round-robin arbiter serialising per-unit put/get requests onto one sem_fifo.
// Each transfer walks IDLE -> ARB -> GRANT -> HOLD with a 4-phase req/ack handshake.
module sem_arbiter
    import sem_arbiter_pkg::*;
#(
    parameter int N_UNITS    = 4,
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 8,
    parameter int IDX_W      = $clog2(N_UNITS),
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_UNITS-1:0]            put_req,
    input  logic [N_UNITS*DATA_WIDTH-1:0] put_data,
    output logic [N_UNITS-1:0]            put_ack,
    input  logic [N_UNITS-1:0]            get_req,
    output logic [DATA_WIDTH-1:0]         get_data,
    output logic [N_UNITS-1:0]            get_valid,
    output logic                          empty,
    output logic                          full,
    output logic [CNT_W-1:0]              count,
    output logic [IDX_W-1:0]              owner,
    output logic                          busy
);
    sa_state_t             state, next_state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      winner;
    logic                  found;
    logic                  op;
    logic [N_UNITS-1:0]    eligible;
    logic                  owner_req;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [N_UNITS-1:0]    owner_onehot;

    // A unit raising both requests has its put considered first.
    assign eligible     = (put_req & ~{N_UNITS{full}}) | (get_req & ~{N_UNITS{empty}});
    assign owner_req    = (op == SA_OP_PUT) ? put_req[owner] : get_req[owner];
    assign owner_onehot = {{(N_UNITS-1){1'b0}}, 1'b1} << owner;
    assign busy         = (state == SA_GRANT) || (state == SA_HOLD);

    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < N_UNITS; i++) begin
            idx = (int'(rr_ptr) + i) % N_UNITS;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SA_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        case (state)
            SA_IDLE:  if (|eligible) next_state = SA_ARB;
            // Requests may have dropped since IDLE; fall back rather than grant nobody.
            SA_ARB:   next_state = found ? SA_GRANT : SA_IDLE;
            SA_GRANT: begin
                fifo_push  = (op == SA_OP_PUT);
                fifo_pop   = (op == SA_OP_GET);
                next_state = SA_HOLD;
            end
            SA_HOLD:  if (!owner_req) next_state = SA_IDLE;
            default:  next_state = SA_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= '0;
            op        <= SA_OP_PUT;
            rr_ptr    <= '0;
            put_ack   <= '0;
            get_valid <= '0;
            get_data  <= '0;
        end else begin
            case (state)
                SA_ARB: if (found) begin
                    owner  <= winner;
                    op     <= (put_req[winner] && !full) ? SA_OP_PUT : SA_OP_GET;
                    rr_ptr <= (winner == IDX_W'(N_UNITS - 1)) ? '0 : winner + 1'b1;
                end
                SA_GRANT: begin
                    if (op == SA_OP_PUT) begin
                        put_ack <= owner_onehot;
                    end else begin
                        get_valid <= owner_onehot;
                        get_data  <= fifo_dout;
                    end
                end
                SA_HOLD: if (!owner_req) begin
                    put_ack   <= '0;
                    get_valid <= '0;
                end
                default: ;
            endcase
        end
    end

    sem_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (put_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH]),
        .dout  (fifo_dout),
        .empty (empty),
        .full  (full),
        .count (count)
    );

endmodule

// File: tb/tb_sem_arbiter.sv
// Directed bench for sem_arbiter: reset, latency, round-robin order, full/empty
// hold-off and FIFO ordering across the pointer wrap.
module tb_sem_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] put_req = '0;
    logic [3:0] put_data = '0;
    logic [3:0] get_req = '0;
    logic [3:0] put_ack;
    logic [0:0] get_data;
    logic [3:0] get_valid;
    logic       empty, full, busy;
    logic [3:0] count;
    logic [1:0] owner;

    int errors = 0;
    int checks = 0;

    localparam logic [17:0] RST_VEC = {4'b0, 4'b0, 1'b0, 2'b0, 1'b0, 1'b1, 1'b0, 4'd0};

    sem_arbiter #(.N_UNITS(4), .DATA_WIDTH(1), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .put_req(put_req), .put_data(put_data), .put_ack(put_ack),
        .get_req(get_req), .get_data(get_data), .get_valid(get_valid), .empty(empty),
        .full(full), .count(count), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] out_vec();
        return {put_ack, get_valid, get_data, owner, busy, empty, full, count};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_evt(output bit to);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ((put_ack | get_valid) != 4'b0) begin
                to = 1'b0;
                return;
            end
        end
    endtask

    task automatic do_reset();
        put_req = '0;
        get_req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One complete handshake; ev = {get_valid, put_ack} seen when the owner is answered.
    task automatic do_op(input int u, input bit is_put, input bit d,
                         output logic [7:0] ev, output logic dat, output bit to);
        if (is_put) begin
            put_data[u] = d;
            put_req[u]  = 1'b1;
        end else begin
            get_req[u] = 1'b1;
        end
        wait_evt(to);
        ev  = {get_valid, put_ack};
        dat = get_data[0];
        put_req[u] = 1'b0;
        get_req[u] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bit to;
        tick();
        checks++;
        if (out_vec() !== RST_VEC) begin
            errors++; $display("FAIL reset_init got=%h exp=%h", out_vec(), RST_VEC);
        end
        rst = 1'b0;
        tick();
        put_data[0] = 1'b1;
        put_req[0]  = 1'b1;
        wait_evt(to);
        checks++;
        if (to || busy !== 1'b1 || count !== 4'd1) begin
            errors++; $display("FAIL reset_pre_hold to=%0b busy=%0b count=%0d exp busy=1 count=1", to, busy, count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_vec() !== RST_VEC) begin
            errors++; $display("FAIL reset_mid_hold got=%h exp=%h", out_vec(), RST_VEC);
        end
        put_req = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] ev;
        logic       dat;
        bit         to;
        put_data[2] = 1'b1;
        put_req[2]  = 1'b1;
        tick(); tick();
        checks++;
        if (put_ack !== 4'b0000) begin
            errors++; $display("FAIL single_early_ack got=%b exp=0000", put_ack);
        end
        tick();
        checks++;
        if (put_ack !== 4'b0100 || count !== 4'd1 || owner !== 2'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL single_put ack=%b count=%0d owner=%0d busy=%0b exp 0100/1/2/1",
                               put_ack, count, owner, busy);
        end
        tick();
        checks++;
        if (put_ack !== 4'b0100) begin
            errors++; $display("FAIL single_hold got=%b exp=0100", put_ack);
        end
        put_req[2] = 1'b0;
        tick();
        checks++;
        if (put_ack !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL single_release ack=%b busy=%0b exp 0000/0", put_ack, busy);
        end
        do_op(0, 1'b0, 1'b0, ev, dat, to);
        checks++;
        if (to || ev !== 8'b0001_0000 || dat !== 1'b1 || empty !== 1'b1 || count !== 4'd0) begin
            errors++; $display("FAIL single_get to=%0b ev=%b data=%0b empty=%0b count=%0d exp 00010000/1/1/0",
                               to, ev, dat, empty, count);
        end
    endtask

    task automatic test_round_robin();
        bit to;
        logic [3:0] pat [2];
        pat[0] = 4'b0110;
        pat[1] = 4'b1001;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            put_data = pat[r];
            put_req  = 4'hF;
            for (int k = 0; k < 4; k++) begin
                wait_evt(to);
                checks++;
                if (to || put_ack !== (4'b0001 << k) || owner !== 2'(k)) begin
                    errors++; $display("FAIL rr_round%0d_grant%0d to=%0b ack=%b owner=%0d exp=%b",
                                       r, k, to, put_ack, owner, 4'b0001 << k);
                end
                put_req[k] = 1'b0;
            end
            tick();
        end
        checks++;
        if (count !== 4'd8 || full !== 1'b1) begin
            errors++; $display("FAIL rr_full count=%0d full=%0b exp 8/1", count, full);
        end
    endtask

    task automatic test_full_empty();
        bit to;
        put_data[1] = 1'b1;
        put_req[1]  = 1'b1;
        get_req[3]  = 1'b1;
        wait_evt(to);
        checks++;
        if (to || {get_valid, put_ack} !== 8'b1000_0000 || get_data !== 1'b0) begin
            errors++; $display("FAIL full_get_first to=%0b ev=%b data=%0b exp 10000000/0",
                               to, {get_valid, put_ack}, get_data);
        end
        get_req[3] = 1'b0;
        wait_evt(to);
        checks++;
        if (to || {get_valid, put_ack} !== 8'b0000_0010) begin
            errors++; $display("FAIL full_put_second to=%0b ev=%b exp 00000010", to, {get_valid, put_ack});
        end
        put_req[1] = 1'b0;
        tick();
        checks++;
        if (count !== 4'd8 || full !== 1'b1) begin
            errors++; $display("FAIL full_final count=%0d full=%0b exp 8/1", count, full);
        end
    endtask

    task automatic test_empty_holdoff();
        bit to;
        bit seen;
        do_reset();
        get_req[1] = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (get_valid != 4'b0 || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL empty_holdoff got=activity exp=none");
        end
        put_data[2] = 1'b0;
        put_req[2]  = 1'b1;
        wait_evt(to);
        checks++;
        if (to || {get_valid, put_ack} !== 8'b0000_0100) begin
            errors++; $display("FAIL empty_put to=%0b ev=%b exp 00000100", to, {get_valid, put_ack});
        end
        put_req[2] = 1'b0;
        wait_evt(to);
        checks++;
        if (to || {get_valid, put_ack} !== 8'b0010_0000 || get_data !== 1'b0) begin
            errors++; $display("FAIL empty_get to=%0b ev=%b data=%0b exp 00100000/0",
                               to, {get_valid, put_ack}, get_data);
        end
        get_req[1] = 1'b0;
        tick();
        checks++;
        if (empty !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL empty_final empty=%0b busy=%0b exp 1/0", empty, busy);
        end
    endtask

    task automatic test_ordering();
        logic [7:0] ev;
        logic       dat;
        bit         to;
        bit         bad;
        logic [3:0] pat;
        pat = 4'b1101;
        do_reset();
        bad = 1'b0;
        // Six put/get pairs walk the pointers up to slot 6 so the next four puts wrap.
        for (int i = 0; i < 6; i++) begin
            do_op(0, 1'b1, i[0], ev, dat, to);
            if (to) bad = 1'b1;
            do_op(0, 1'b0, 1'b0, ev, dat, to);
            if (to || dat !== i[0]) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL order_warmup got=bad exp=clean");
        end
        for (int u = 0; u < 4; u++) begin
            do_op(u, 1'b1, pat[u], ev, dat, to);
            checks++;
            if (to || ev !== {4'b0, 4'b0001 << u}) begin
                errors++; $display("FAIL order_put%0d to=%0b ev=%b", u, to, ev);
            end
        end
        for (int k = 0; k < 4; k++) begin
            do_op(2, 1'b0, 1'b0, ev, dat, to);
            checks++;
            if (to || ev !== 8'b0100_0000 || dat !== pat[k]) begin
                errors++; $display("FAIL order_get%0d to=%0b ev=%b data=%0b exp=%0b", k, to, ev, dat, pat[k]);
            end
        end
        checks++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL order_final count=%0d empty=%0b exp 0/1", count, empty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_empty();
        test_empty_holdoff();
        test_ordering();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
